// File: rtl/vid_timing_monitor.sv
// Video timing monitor: checks hsync/vsync cadence against expected timing,
// locks on clean frames and reports an active-pixel checksum per good frame.
module vid_timing_monitor #(
  parameter int unsigned ColorWidth    = 8,
  parameter int unsigned CntWidth      = 12,
  parameter int unsigned HSyncLen      = 96,
  parameter int unsigned HBackPorch    = 48,
  parameter int unsigned HActive       = 640,
  parameter int unsigned HFrontPorch   = 16,
  parameter int unsigned VSyncLen      = 2,
  parameter int unsigned VBackPorch    = 33,
  parameter int unsigned VActive       = 480,
  parameter int unsigned VFrontPorch   = 10,
  parameter bit          SyncActiveLow = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic                  hsync_i,
  input  logic                  vsync_i,
  input  logic [ColorWidth-1:0] red_i,
  input  logic [ColorWidth-1:0] green_i,
  input  logic [ColorWidth-1:0] blue_i,
  output logic                  locked_o,
  output logic                  frame_done_o,
  output logic [31:0]           frame_sum_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  err_h_o,
  output logic                  err_v_o
);

  localparam int unsigned HTotal    = HSyncLen + HBackPorch + HActive + HFrontPorch;
  localparam int unsigned VTotal    = VSyncLen + VBackPorch + VActive + VFrontPorch;
  localparam int unsigned HActStart = HSyncLen + HBackPorch;
  localparam int unsigned HActEnd   = HActStart + HActive;
  localparam int unsigned VActStart = VSyncLen + VBackPorch;
  localparam int unsigned VActEnd   = VActStart + VActive;
  localparam int unsigned PixWidth  = 3 * ColorWidth;

  localparam logic [CntWidth-1:0] HTotM1  = CntWidth'(HTotal - 1);
  localparam logic [CntWidth-1:0] VTotM1  = CntWidth'(VTotal - 1);
  localparam logic [CntWidth-1:0] HSyncC  = CntWidth'(HSyncLen);
  localparam logic [CntWidth-1:0] VSyncC  = CntWidth'(VSyncLen);
  localparam logic [CntWidth-1:0] HActS   = CntWidth'(HActStart);
  localparam logic [CntWidth-1:0] HActE   = CntWidth'(HActEnd);
  localparam logic [CntWidth-1:0] VActS   = CntWidth'(VActStart);
  localparam logic [CntWidth-1:0] VActE   = CntWidth'(VActEnd);
  localparam logic [CntWidth-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEEK,
    ST_MEASURE,
    ST_LOCKED
  } state_e;

  state_e                r_state, w_state_nxt;
  logic                  r_hs, r_vs, r_hs_d, r_vs_smp;
  logic [PixWidth-1:0]   r_pix;
  logic [CntWidth-1:0]   r_hcnt, r_lcnt, w_hcnt, w_lcnt;
  logic [31:0]           r_acc, r_sum_pend, w_pix32;
  logic                  r_frm_err, w_frm_err_nxt, r_done_pend;
  logic                  r_locked, r_done, r_err_h, r_err_v;
  logic [31:0]           r_sum;
  logic [15:0]           r_cnt;
  logic                  w_hs_rise, w_hs_fall, w_fs, w_vs_end, w_checking;
  logic                  w_err_h, w_err_v, w_err, w_active, w_frame_ok, w_emit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_pix  <= '0;
    end else begin
      r_hs   <= SyncActiveLow ? ~hsync_i : hsync_i;
      r_vs   <= SyncActiveLow ? ~vsync_i : vsync_i;
      r_hs_d <= r_hs;
      r_pix  <= {red_i, green_i, blue_i};
    end
  end

  // Counts are computed combinationally so w_hcnt/w_lcnt line up with the
  // registered sync/pixel stage; r_hcnt/r_lcnt hold the previous cycle's value.
  assign w_hs_rise = r_hs & ~r_hs_d;
  assign w_hs_fall = ~r_hs & r_hs_d;
  assign w_fs      = w_hs_rise & r_vs & ~r_vs_smp;
  assign w_vs_end  = w_hs_rise & ~r_vs & r_vs_smp;
  assign w_hcnt    = w_hs_rise ? '0 : ((r_hcnt == CntMax) ? r_hcnt : r_hcnt + 1'b1);

  always_comb begin
    w_lcnt = r_lcnt;
    if (w_fs) begin
      w_lcnt = '0;
    end else if (w_hs_rise && (r_lcnt != CntMax)) begin
      w_lcnt = r_lcnt + 1'b1;
    end
  end

  assign w_checking = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);
  assign w_err_h    = w_checking & ((w_hs_rise & (r_hcnt != HTotM1)) |
                                    (w_hs_fall & (w_hcnt != HSyncC)));
  assign w_err_v    = w_checking & ((w_fs & (r_lcnt != VTotM1)) |
                                    (w_vs_end & (w_lcnt != VSyncC)));
  assign w_err      = w_err_h | w_err_v;
  assign w_active   = (w_hcnt >= HActS) && (w_hcnt < HActE) &&
                      (w_lcnt >= VActS) && (w_lcnt < VActE);
  assign w_pix32    = 32'(r_pix);
  assign w_frame_ok = w_fs & w_checking & ~r_frm_err & ~w_err;
  assign w_emit     = r_done_pend & en_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (en_i) w_state_nxt = ST_SEEK;
      ST_SEEK:    if (w_fs) w_state_nxt = ST_MEASURE;
      ST_MEASURE: if (w_frame_ok) w_state_nxt = ST_LOCKED;
      ST_LOCKED:  if (w_err) w_state_nxt = ST_MEASURE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (!en_i) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    w_frm_err_nxt = r_frm_err;
    if (w_fs) begin
      w_frm_err_nxt = 1'b0;
    end else if (w_err) begin
      w_frm_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_vs_smp    <= 1'b0;
      r_acc       <= '0;
      r_frm_err   <= 1'b0;
      r_done_pend <= 1'b0;
      r_sum_pend  <= '0;
    end else if (!en_i) begin
      r_hcnt      <= '0;
      r_lcnt      <= '0;
      r_vs_smp    <= 1'b0;
      r_acc       <= '0;
      r_frm_err   <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      r_hcnt      <= w_hcnt;
      r_lcnt      <= w_lcnt;
      r_frm_err   <= w_frm_err_nxt;
      r_done_pend <= w_frame_ok;
      if (w_hs_rise) r_vs_smp <= r_vs;
      if (w_frame_ok) r_sum_pend <= r_acc;
      if (w_fs) begin
        r_acc <= w_active ? w_pix32 : '0;
      end else if (w_active) begin
        r_acc <= r_acc + w_pix32;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_err_h  <= 1'b0;
      r_err_v  <= 1'b0;
    end else begin
      r_locked <= (w_state_nxt == ST_LOCKED);
      r_done   <= w_emit;
      if (w_emit) r_sum <= r_sum_pend;
      if (clr_i) begin
        r_cnt <= '0;
      end else if (w_emit) begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_err_h <= w_err_h | (r_err_h & ~clr_i);
      r_err_v <= w_err_v | (r_err_v & ~clr_i);
    end
  end

  assign locked_o     = r_locked;
  assign frame_done_o = r_done;
  assign frame_sum_o  = r_sum;
  assign frame_cnt_o  = r_cnt;
  assign err_h_o      = r_err_h;
  assign err_v_o      = r_err_v;

endmodule

// File: tb/tb_vid_timing_monitor.sv
// Directed bench for vid_timing_monitor with a reduced 10x5 timing
// (H 2/2/4/2, V 1/1/2/1, active-low syncs).
module tb_vid_timing_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni, en_i, clr_i, hsync_i, vsync_i;
  logic [7:0]  red_i, green_i, blue_i;
  logic        locked_o, frame_done_o, err_h_o, err_v_o;
  logic [31:0] frame_sum_o;
  logic [15:0] frame_cnt_o;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          pulse_cyc[$];
  logic [15:0] pulse_cnt[$];
  logic [31:0] pulse_sum[$];

  vid_timing_monitor #(
    .ColorWidth   (8),
    .CntWidth     (12),
    .HSyncLen     (2),
    .HBackPorch   (2),
    .HActive      (4),
    .HFrontPorch  (2),
    .VSyncLen     (1),
    .VBackPorch   (1),
    .VActive      (2),
    .VFrontPorch  (1),
    .SyncActiveLow(1'b1)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .hsync_i     (hsync_i),
    .vsync_i     (vsync_i),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .locked_o    (locked_o),
    .frame_done_o(frame_done_o),
    .frame_sum_o (frame_sum_o),
    .frame_cnt_o (frame_cnt_o),
    .err_h_o     (err_h_o),
    .err_v_o     (err_v_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (frame_done_o === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
      pulse_cnt.push_back(frame_cnt_o);
      pulse_sum.push_back(frame_sum_o);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_line(input int len, input bit vs, input int clr_col);
    for (int c = 0; c < len; c++) begin
      hsync_i = (c < 2) ? 1'b0 : 1'b1;
      vsync_i = vs ? 1'b0 : 1'b1;
      clr_i   = (c == clr_col);
      tick();
    end
    clr_i = 1'b0;
  endtask

  task automatic send_frame(input int short_line, input int vs_lines, input int clr_line,
                            input int clr_col, output int fs_cyc);
    fs_cyc = cyc;
    for (int l = 0; l < 5; l++) begin
      send_line((l == short_line) ? 9 : 10, l < vs_lines, (l == clr_line) ? clr_col : -1);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b1; en_i = 1'b0; clr_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    red_i = 8'h01; green_i = 8'h00; blue_i = 8'h00;
    #1 rst_ni = 1'b0;
    #1;
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL reset_locked: got %0h expected 0", locked_o); end
    checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL reset_done: got %0h expected 0", frame_done_o); end
    checks++; if (frame_sum_o !== 32'h0) begin failures++; $display("FAIL reset_sum: got %0h expected 0", frame_sum_o); end
    checks++; if (frame_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_cnt: got %0h expected 0", frame_cnt_o); end
    checks++; if (err_h_o !== 1'b0) begin failures++; $display("FAIL reset_err_h: got %0h expected 0", err_h_o); end
    checks++; if (err_v_o !== 1'b0) begin failures++; $display("FAIL reset_err_v: got %0h expected 0", err_v_o); end
    tick(); tick();
    #2 rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_clean_lock();
    int fs, fs2, p0;
    en_i = 1'b1;
    tick(); tick(); tick();
    pulse_cyc.delete(); pulse_cnt.delete(); pulse_sum.delete();
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL lock_first_frame: got %0h expected 0", locked_o); end
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL lock_first_pulses: got %0d expected 0", pulses - p0); end
    send_frame(-1, 1, -1, 0, fs2);
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulse_cyc.size() !== 2) begin failures++; $display("FAIL lock_pulse_count: got %0d expected 2", pulse_cyc.size()); end
    if (pulse_cyc.size() >= 2) begin
      checks++; if (pulse_cyc[0] !== fs2 + 3) begin failures++; $display("FAIL lock_latency: got %0d expected %0d", pulse_cyc[0], fs2 + 3); end
      checks++; if (pulse_cnt[0] !== 16'd1) begin failures++; $display("FAIL lock_first_cnt: got %0d expected 1", pulse_cnt[0]); end
      checks++; if (pulse_sum[0] !== 32'h0008_0000) begin failures++; $display("FAIL lock_first_sum: got %0h expected 80000", pulse_sum[0]); end
      checks++; if (pulse_cyc[1] - pulse_cyc[0] !== 50) begin failures++; $display("FAIL lock_interval: got %0d expected 50", pulse_cyc[1] - pulse_cyc[0]); end
    end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL lock_locked: got %0h expected 1", locked_o); end
    checks++; if (frame_cnt_o !== 16'd2) begin failures++; $display("FAIL lock_cnt: got %0d expected 2", frame_cnt_o); end
    checks++; if (frame_sum_o !== 32'h0008_0000) begin failures++; $display("FAIL lock_sum: got %0h expected 80000", frame_sum_o); end
  endtask

  task automatic test_short_line();
    int fs, p0;
    p0 = pulses;
    send_frame(2, 1, -1, 0, fs);
    checks++; if (err_h_o !== 1'b1) begin failures++; $display("FAIL short_err_h: got %0h expected 1", err_h_o); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL short_unlock: got %0h expected 0", locked_o); end
    checks++; if (frame_cnt_o !== 16'd3) begin failures++; $display("FAIL short_cnt_a: got %0d expected 3", frame_cnt_o); end
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL short_no_pulse: got %0d expected 0", pulses - p0); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL short_still_unlocked: got %0h expected 0", locked_o); end
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL short_relock_pulse: got %0d expected 1", pulses - p0); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL short_relock: got %0h expected 1", locked_o); end
    checks++; if (frame_cnt_o !== 16'd4) begin failures++; $display("FAIL short_cnt_c: got %0d expected 4", frame_cnt_o); end
  endtask

  task automatic test_vsync_wide();
    int fs, p0;
    send_frame(-1, 2, 0, 5, fs);
    checks++; if (err_v_o !== 1'b1) begin failures++; $display("FAIL vwide_err_v: got %0h expected 1", err_v_o); end
    checks++; if (err_h_o !== 1'b0) begin failures++; $display("FAIL vwide_err_h_cleared: got %0h expected 0", err_h_o); end
    checks++; if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL vwide_cnt_cleared: got %0d expected 0", frame_cnt_o); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL vwide_unlock: got %0h expected 0", locked_o); end
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL vwide_not_counted: got %0d expected 0", pulses - p0); end
    checks++; if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL vwide_cnt_hold: got %0d expected 0", frame_cnt_o); end
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (frame_cnt_o !== 16'd1) begin failures++; $display("FAIL vwide_relock_cnt: got %0d expected 1", frame_cnt_o); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL vwide_relock: got %0h expected 1", locked_o); end
  endtask

  task automatic test_clr_collision();
    int fs;
    send_frame(2, 1, 3, 1, fs);
    checks++; if (err_h_o !== 1'b1) begin failures++; $display("FAIL clr_err_h_wins: got %0h expected 1", err_h_o); end
    checks++; if (err_v_o !== 1'b0) begin failures++; $display("FAIL clr_err_v_cleared: got %0h expected 0", err_v_o); end
    checks++; if (frame_cnt_o !== 16'd0) begin failures++; $display("FAIL clr_cnt_zero: got %0d expected 0", frame_cnt_o); end
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL clr_unlock: got %0h expected 0", locked_o); end
  endtask

  task automatic test_enable_drop();
    int fs, p0;
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL en_lock_pulse: got %0d expected 1", pulses - p0); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL en_locked: got %0h expected 1", locked_o); end
    send_line(10, 1'b1, -1);
    send_line(10, 1'b0, -1);
    checks++; if (frame_cnt_o !== 16'd2) begin failures++; $display("FAIL en_cnt_before_drop: got %0d expected 2", frame_cnt_o); end
    en_i = 1'b0;
    tick();
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL en_drop_unlock: got %0h expected 0", locked_o); end
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL en_off_pulses: got %0d expected 0", pulses - p0); end
    checks++; if (frame_cnt_o !== 16'd2) begin failures++; $display("FAIL en_off_cnt_kept: got %0d expected 2", frame_cnt_o); end
    checks++; if (frame_sum_o !== 32'h0008_0000) begin failures++; $display("FAIL en_off_sum_kept: got %0h expected 80000", frame_sum_o); end
    en_i = 1'b1;
    tick(); tick();
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 0) begin failures++; $display("FAIL en_seek_no_pulse: got %0d expected 0", pulses - p0); end
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL en_reenable_pulse: got %0d expected 1", pulses - p0); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL en_reenable_lock: got %0h expected 1", locked_o); end
    checks++; if (frame_cnt_o !== 16'd3) begin failures++; $display("FAIL en_reenable_cnt: got %0d expected 3", frame_cnt_o); end
  endtask

  task automatic test_reset_midframe();
    int fs, p0;
    send_line(10, 1'b1, -1);
    send_line(10, 1'b0, -1);
    #3 rst_ni = 1'b0;
    #1;
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL mid_rst_locked: got %0h expected 0", locked_o); end
    checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL mid_rst_done: got %0h expected 0", frame_done_o); end
    checks++; if (frame_sum_o !== 32'h0) begin failures++; $display("FAIL mid_rst_sum: got %0h expected 0", frame_sum_o); end
    checks++; if (frame_cnt_o !== 16'h0) begin failures++; $display("FAIL mid_rst_cnt: got %0h expected 0", frame_cnt_o); end
    checks++; if (err_h_o !== 1'b0) begin failures++; $display("FAIL mid_rst_err_h: got %0h expected 0", err_h_o); end
    checks++; if (err_v_o !== 1'b0) begin failures++; $display("FAIL mid_rst_err_v: got %0h expected 0", err_v_o); end
    @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();
    p0 = pulses;
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (locked_o !== 1'b0) begin failures++; $display("FAIL mid_rst_no_early_lock: got %0h expected 0", locked_o); end
    send_frame(-1, 1, -1, 0, fs);
    checks++; if (pulses - p0 !== 1) begin failures++; $display("FAIL mid_rst_relock_pulse: got %0d expected 1", pulses - p0); end
    checks++; if (locked_o !== 1'b1) begin failures++; $display("FAIL mid_rst_relock: got %0h expected 1", locked_o); end
    checks++; if (frame_cnt_o !== 16'd1) begin failures++; $display("FAIL mid_rst_cnt_after: got %0d expected 1", frame_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_short_line();
    test_vsync_wide();
    test_clr_collision();
    test_enable_drop();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vid_timing_monitor.md
VID_TIMING_MONITOR -- requirements
Module: vid_timing_monitor

Interface
REQ-001 SHALL take parameter ColorWidth, default 8, as bits per colour channel.
REQ-002 SHALL take parameter CntWidth, default 12, as width of the horizontal and line counters.
REQ-003 SHALL take parameters HSyncLen=96, HBackPorch=48, HActive=640, HFrontPorch=16 as expected horizontal timing in clock cycles.
REQ-004 SHALL take parameters VSyncLen=2, VBackPorch=33, VActive=480, VFrontPorch=10 as expected vertical timing in lines.
REQ-005 SHALL take parameter SyncActiveLow, default 1, as 1 = hsync_i/vsync_i asserted when low.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock.
REQ-007 SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port en_i, input, 1 bit: monitor enable.
REQ-009 SHALL have port clr_i, input, 1 bit: clear sticky errors and frame_cnt_o.
REQ-010 SHALL have ports hsync_i and vsync_i, input, 1 bit each: display sync.
REQ-011 SHALL have ports red_i, green_i, blue_i, input, ColorWidth each: pixel data.
REQ-012 SHALL have port locked_o, output, 1 bit: timing locked.
REQ-013 SHALL have port frame_done_o, output, 1 bit: single-cycle pulse, frame result valid.
REQ-014 SHALL have port frame_sum_o, output, 32 bits: active-pixel checksum of last good frame.
REQ-015 SHALL have port frame_cnt_o, output, 16 bits: good frames counted.
REQ-016 SHALL have ports err_h_o and err_v_o, output, 1 bit each: sticky horizontal and vertical timing errors.

Function
REQ-017 SHALL register all inputs once; all logic below operates on the registered stage, with polarity normalised so 1 = asserted.
REQ-018 SHALL define HTotal as the sum of the four H parameters and VTotal as the sum of the four V parameters.
REQ-019 SHALL set h_cnt to 0 in the first registered cycle of hsync assertion, else increment it, saturating at all-ones.
REQ-020 SHALL, at each hsync-assert cycle, sample vsync as frame start when vsync is asserted and the previously sampled vsync was not; on frame start set l_cnt=0, otherwise l_cnt+1, saturating.
REQ-021 SHALL flag an H error when, at hsync assert, the prior h_cnt is not HTotal-1, or when, at the first hsync-deasserted cycle, h_cnt is not HSyncLen.
REQ-022 SHALL flag a V error when, at frame start, the prior l_cnt is not VTotal-1, or when, at the first hsync-assert with vsync deasserted, the new l_cnt is not VSyncLen.
REQ-023 SHALL treat a pixel as active iff h_cnt is in [HSyncLen+HBackPorch, HSyncLen+HBackPorch+HActive) and l_cnt is in [VSyncLen+VBackPorch, VSyncLen+VBackPorch+VActive).
REQ-024 SHALL, for each active pixel, add zero-extended {red,green,blue} to a 32-bit accumulator modulo 2^32.
REQ-025 SHALL implement an FSM IDLE -> SEEK on en_i=1 -> MEASURE on first frame start -> LOCKED on a frame start ending an error-free frame.
REQ-026 SHALL, in LOCKED, move to MEASURE on any H/V error.
REQ-027 SHALL, in MEASURE, stay in MEASURE on a frame start ending an errored frame, clearing the per-frame error flag.
REQ-028 SHALL force IDLE from any state when en_i=0, clearing counters, accumulator and the per-frame flag; frame_cnt_o and frame_sum_o are retained.
REQ-029 SHALL evaluate error checks only in MEASURE and LOCKED; SEEK only counts.
REQ-030 SHALL drive locked_o = (state==LOCKED), registered.
REQ-031 SHALL, on a frame start that ends an error-free frame in MEASURE or LOCKED, load frame_sum_o with the accumulator, increment frame_cnt_o (wrapping at 2^16) and pulse frame_done_o for one cycle, 2 cycles after the raw sync edge is sampled; the accumulator restarts at 0 that cycle.
REQ-032 SHALL, when an error occurs in the same cycle as a frame start, count that frame as errored.
REQ-033 SHALL set err_h_o/err_v_o on their errors until clr_i; when clr_i coincides with a new error, the error wins; clr_i also zeroes frame_cnt_o.

Reset
REQ-034 SHALL, while rst_ni=0, asynchronously force state IDLE and all outputs, counters, accumulator and input registers to 0 (input registers hold the deasserted-sync level).

Verification
REQ-035 SHALL cover reset: assert rst_ni mid-frame -> all outputs 0 immediately; after release with en_i=1, locked_o stays 0 until a full clean frame.
REQ-036 SHALL cover clean lock with H=2/2/4/2, V=1/1/2/1 (HTotal 10, VTotal 5) and RGB constant 0x010000 -> first frame_done_o at the second frame start, locked_o=1, frame_sum_o=0x00080000, frame_cnt_o=1, then a pulse every 50 cycles.
REQ-037 SHALL cover a short line: one line of 9 cycles while locked -> err_h_o=1, locked_o=0, no pulse for that frame, relock after the next clean frame.
REQ-038 SHALL cover a vsync 2 lines wide (VSyncLen=1) -> err_v_o=1, frame not counted.
REQ-039 SHALL cover clr_i in the same cycle as an H error -> err_h_o stays 1 and frame_cnt_o goes to 0.
REQ-040 SHALL cover en_i dropped mid-frame -> IDLE next cycle, locked_o=0, no pulse; on re-enable, SEEK then MEASURE.
